// File: rtl/matmul_pkg.sv
// Shared types and helpers for the streaming N x N matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Saturates to the signed ow-bit range when sat is set; the caller keeps the low ow bits.
  function automatic logic signed [63:0] narrow(input logic signed [63:0] v,
                                                input int ow, input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (sat && (v > hi)) return hi;
    if (sat && (v < lo)) return lo;
    return v;
  endfunction

endpackage

// File: rtl/matmul_nxn_stream_mac.sv
// Signed DW x DW multiply feeding an ACCW-bit accumulator with clear and enable.
module matmul_mac #(
  parameter int DW   = 4,
  parameter int ACCW = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic signed [DW-1:0]   i_a,
  input  logic signed [DW-1:0]   i_b,
  output logic signed [ACCW-1:0] o_sum
);

  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] r_acc;

  assign w_prod = i_a * i_b;
  assign o_sum  = r_acc + ACCW'(w_prod);

  // o_sum is the completed dot product on the clearing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_clr ? '0 : o_sum;
    end
  end

endmodule

// File: rtl/matmul_nxn_stream.sv
// Streaming signed C = A x B: load 2*N*N operands, one MAC per cycle, drain N*N results.
//   state      | meaning
//   ST_LOAD    | accept A then B elements, row-major
//   ST_COMPUTE | N^3 MAC cycles, i/j/k nested, fill C buffer
//   ST_DRAIN   | stream C out row-major with the job error flag
module matmul_nxn_stream
  import matmul_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 4,
  parameter int OW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 sat_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 out_err,
  output logic                 busy
);

  localparam int ACCW = 2*DW + clog2(N);
  localparam int NN   = N*N;
  localparam int LW   = clog2(2*NN);
  localparam int IW   = clog2(N);
  localparam int CW   = clog2(NN);

  logic signed [DW-1:0] r_op [2*NN];
  logic signed [OW-1:0] r_c  [NN];

  state_t          r_state;
  logic [LW-1:0]   r_lidx;
  logic [IW-1:0]   r_i, r_j, r_k;
  logic [CW-1:0]   r_oidx;
  logic            r_err;
  logic            r_sat;

  logic                   w_in_hs;
  logic                   w_out_hs;
  logic                   w_last_k;
  logic                   w_mac_en;
  logic                   w_is_min;
  logic signed [DW-1:0]   w_a;
  logic signed [DW-1:0]   w_b;
  logic signed [ACCW-1:0] w_sum;
  logic signed [OW-1:0]   w_cval;
  logic [CW-1:0]          w_cidx;

  assign in_ready  = rst_n & ena & (r_state == ST_LOAD);
  assign out_valid = ena & (r_state == ST_DRAIN);
  assign out_data  = (r_state == ST_DRAIN) ? r_c[r_oidx] : '0;
  assign out_err   = (r_state == ST_DRAIN) & r_err;
  assign busy      = (r_state != ST_LOAD);

  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = out_valid & out_ready;
  assign w_last_k = (r_k == IW'(N-1));
  assign w_mac_en = ena & (r_state == ST_COMPUTE);
  assign w_is_min = (in_data == {1'b1, {(DW-1){1'b0}}});

  assign w_a    = r_op[LW'(int'(r_i)*N + int'(r_k))];
  assign w_b    = r_op[LW'(NN + int'(r_k)*N + int'(r_j))];
  assign w_cidx = CW'(int'(r_i)*N + int'(r_j));
  assign w_cval = r_err ? '0 : OW'(narrow(64'(w_sum), OW, r_sat));

  matmul_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_mac_en),
    .i_clr (w_last_k),
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_sum)
  );

  // Operand and result storage carry no reset; the sequencer never reads stale slots.
  always_ff @(posedge clk) begin
    if (w_in_hs) r_op[r_lidx] <= in_data;
    if (w_mac_en && w_last_k) r_c[w_cidx] <= w_cval;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_lidx  <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_oidx  <= '0;
      r_err   <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_hs) begin
            r_err <= (r_lidx == '0) ? w_is_min : (r_err | w_is_min);
            if (r_lidx == LW'(2*NN-1)) begin
              r_lidx  <= '0;
              r_sat   <= sat_en;
              r_state <= ST_COMPUTE;
            end else begin
              r_lidx <= r_lidx + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (ena) begin
            if (w_last_k) begin
              r_k <= '0;
              if (r_j == IW'(N-1)) begin
                r_j <= '0;
                if (r_i == IW'(N-1)) begin
                  r_i     <= '0;
                  r_state <= ST_DRAIN;
                end else begin
                  r_i <= r_i + 1'b1;
                end
              end else begin
                r_j <= r_j + 1'b1;
              end
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_out_hs) begin
            if (r_oidx == CW'(NN-1)) begin
              r_oidx  <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_oidx <= r_oidx + 1'b1;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_nxn_stream.sv
// Directed bench: an OW=8 and an OW=6 instance run in lockstep on shared stimulus.
module tb_matmul_nxn_stream;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       sat_en;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       in_ready, out_valid, out_err, busy;
  logic [7:0] out_data8;
  logic       in_ready6, out_valid6, out_err6, busy6;
  logic [5:0] out_data6;

  int checks;
  int failures;

  logic [3:0] job [8];
  logic [7:0] got8 [4];
  logic [5:0] got6 [4];
  logic       gote [4];
  int         got_first;
  int         got_nb;

  matmul_nxn_stream #(.N(2), .DW(4), .OW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data8),
    .out_err(out_err), .busy(busy)
  );

  matmul_nxn_stream #(.N(2), .DW(4), .OW(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready6), .in_data(in_data),
    .out_valid(out_valid6), .out_ready(out_ready), .out_data(out_data6),
    .out_err(out_err6), .busy(busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_basic();
    job = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'h9};
  endtask

  task automatic send_job(input logic sat, input bit rnd, output bit ok);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    while (idx < 8 && guard < 300) begin
      @(negedge clk);
      guard++;
      out_ready = 1'b1;
      in_valid  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data   = job[idx];
      sat_en    = sat;
      #1;
      if (in_valid && in_ready) idx++;
    end
    ok = (idx == 8);
  endtask

  // t counts clock edges after the final input handshake.
  task automatic collect();
    int t;
    t = -1;
    got_nb = 0;
    got_first = -1;
    while (got_nb < 4 && t < 300) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      t++;
      if (out_valid) begin
        if (got_nb == 0) got_first = t;
        got8[got_nb] = out_data8;
        got6[got_nb] = out_valid6 ? out_data6 : 6'bx;
        gote[got_nb] = out_err;
        got_nb++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; sat_en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data8 !== 8'h00 || out_err !== 1'b0 ||
        busy !== 1'b0 || in_ready6 !== 1'b0 || busy6 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h err=%b busy=%b rdy6=%b busy6=%b expected all 0",
               in_ready, out_valid, out_data8, out_err, busy, in_ready6, busy6);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b busy=%b expected rdy=1 busy=0", in_ready, busy);
    end
    @(negedge clk);
    ena = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ena_low_load: got in_ready=%b expected 0", in_ready);
    end
    @(negedge clk);
    ena = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp8 [4] = '{8'h13, 8'hF8, 8'h2B, 8'hF6};
    bit ok;
    set_basic();
    send_job(1'b0, 1'b0, ok);
    collect();
    checks++;
    if (!ok || got_nb != 4) begin
      failures++;
      $display("FAIL basic_transfer: got in_ok=%0d beats=%0d expected 1 and 4", ok, got_nb);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got8[b] !== exp8[b] || gote[b] !== 1'b0) begin
        failures++;
        $display("FAIL basic_c%0d: got %h err=%b expected %h err=0", b, got8[b], gote[b], exp8[b]);
      end
    end
    checks++;
    if (got_first != 8) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected 8", got_first);
    end
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_next_ready: got rdy=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_sat_wrap();
    bit ok;
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 8; s++) job[s] = 4'd7;
      send_job((m == 0), 1'b0, ok);
      collect();
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (got6[b] !== ((m == 0) ? 6'h1F : 6'h22) || got8[b] !== 8'h62) begin
          failures++;
          $display("FAIL sat_wrap_m%0d_c%0d: got ow6=%h ow8=%h expected ow6=%h ow8=62",
                   m, b, got6[b], got8[b], (m == 0) ? 6'h1F : 6'h22);
        end
      end
    end
  endtask

  task automatic test_error();
    logic [7:0] exp8 [4] = '{8'h13, 8'hF8, 8'h2B, 8'hF6};
    bit ok;
    job = '{4'd1, 4'h8, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'h9};
    send_job(1'b1, 1'b0, ok);
    collect();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got8[b] !== 8'h00 || got6[b] !== 6'h00 || gote[b] !== 1'b1) begin
        failures++;
        $display("FAIL error_c%0d: got %h/%h err=%b expected 00/00 err=1", b, got8[b], got6[b], gote[b]);
      end
    end
    set_basic();
    send_job(1'b0, 1'b0, ok);
    collect();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got8[b] !== exp8[b] || gote[b] !== 1'b0) begin
        failures++;
        $display("FAIL error_clear_c%0d: got %h err=%b expected %h err=0", b, got8[b], gote[b], exp8[b]);
      end
    end
  endtask

  task automatic test_in_backpressure();
    logic [7:0] exp8 [4] = '{8'h13, 8'hF8, 8'h2B, 8'hF6};
    bit ok;
    set_basic();
    send_job(1'b0, 1'b1, ok);
    collect();
    checks++;
    if (!ok || got_nb != 4 || got_first != 8) begin
      failures++;
      $display("FAIL in_bp_transfer: got ok=%0d beats=%0d lat=%0d expected 1 4 8", ok, got_nb, got_first);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got8[b] !== exp8[b]) begin
        failures++;
        $display("FAIL in_bp_c%0d: got %h expected %h", b, got8[b], exp8[b]);
      end
    end
  endtask

  task automatic test_out_backpressure();
    bit ok;
    int guard;
    set_basic();
    send_job(1'b0, 1'b0, ok);
    guard = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      guard++;
    end while (!out_valid && guard < 100);
    checks++;
    if (out_valid !== 1'b1 || out_data8 !== 8'h13) begin
      failures++;
      $display("FAIL out_bp_beat0: got vld=%b data=%h expected 1 13", out_valid, out_data8);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data8 !== 8'hF8) begin
        failures++;
        $display("FAIL out_bp_hold%0d: got vld=%b data=%h expected 1 F8", c, out_valid, out_data8);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_data8 !== 8'hF8) begin
      failures++;
      $display("FAIL out_bp_beat1: got %h expected F8", out_data8);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data8 !== 8'h2B) begin
      failures++;
      $display("FAIL out_bp_beat2: got vld=%b data=%h expected 1 2B", out_valid, out_data8);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data8 !== 8'hF6) begin
      failures++;
      $display("FAIL out_bp_beat3: got vld=%b data=%h expected 1 F6", out_valid, out_data8);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL out_bp_done: got vld=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_ena();
    logic [7:0] exp8 [4] = '{8'h13, 8'hF8, 8'h2B, 8'hF6};
    bit ok;
    int t;
    set_basic();
    send_job(1'b0, 1'b0, ok);
    t = -1;
    got_nb = 0;
    got_first = -1;
    while (got_nb < 4 && t < 300) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      t++;
      ena = (t >= 2 && t < 5) ? 1'b0 : 1'b1;
      #1;
      if (!ena) begin
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ena_freeze_t%0d: got busy=%b vld=%b rdy=%b expected 1 0 0", t, busy, out_valid, in_ready);
        end
      end
      if (out_valid) begin
        if (got_nb == 0) got_first = t;
        got8[got_nb] = out_data8;
        got_nb++;
      end
    end
    ena = 1'b1;
    checks++;
    if (got_first != 11 || got_nb != 4) begin
      failures++;
      $display("FAIL ena_latency: got lat=%0d beats=%0d expected 11 4", got_first, got_nb);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got8[b] !== exp8[b]) begin
        failures++;
        $display("FAIL ena_c%0d: got %h expected %h", b, got8[b], exp8[b]);
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] exp8 [4] = '{8'h13, 8'hF8, 8'h2B, 8'hF6};
    bit ok;
    set_basic();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = job[c];
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data8 !== 8'h00 || out_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midload_reset: got rdy=%b vld=%b data=%h err=%b busy=%b expected all 0",
               in_ready, out_valid, out_data8, out_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_job(1'b0, 1'b0, ok);
    collect();
    checks++;
    if (!ok || got_nb != 4 || got_first != 8) begin
      failures++;
      $display("FAIL midload_transfer: got ok=%0d beats=%0d lat=%0d expected 1 4 8", ok, got_nb, got_first);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got8[b] !== exp8[b] || gote[b] !== 1'b0) begin
        failures++;
        $display("FAIL midload_c%0d: got %h err=%b expected %h err=0", b, got8[b], gote[b], exp8[b]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_sat_wrap();
    test_error();
    test_in_backpressure();
    test_out_backpressure();
    test_ena();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
